chksum_inet_acc: RTL and testbench

CHKSUM_INET_ACC -- requirements
Module: chksum_inet_acc

---
 rtl/chksum_inet_acc.sv | 233 +++++++++++++++++++++++
 tb/tb_chksum_inet_acc.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/chksum_inet_acc.sv
// -----------------------------------------------------------------------------
// chksum_inet_acc
//
// Streaming Internet (RFC 1071 style) ones-complement checksum accumulator.
// Payload beats are byte-masked, split into big-endian 16-bit words and summed
// into a wide accumulator that carries its own end-around overflow between
// beats. The final 16-bit fold happens on the last beat. The result is
// registered, so it is stable for the whole time the result is presented.
//
// Ports
//   clk       : rising-edge clock
//   reset     : asynchronous active-low reset
//   s_data    : payload beat, byte 0 in the most significant byte (network order)
//   s_keep    : byte enables, MSB qualifies byte 0
//   s_valid   : beat valid
//   s_last    : final beat of frame
//   s_ready   : beat accepted on s_valid && s_ready
//   seed      : initial 16-bit sum (pseudo-header), taken on the first beat
//   mode      : 0 = generate, 1 = verify, taken on the first beat
//   flush     : synchronous abort of the current frame or pending result
//   m_chksum  : ones-complement checksum (0000 in verify mode when it checks)
//   m_ok      : folded sum equals FFFF
//   m_len     : accepted byte count, saturating
//   m_valid   : result valid
//   m_ready   : result consumed on m_valid && m_ready
// -----------------------------------------------------------------------------
module chksum_inet_acc #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_W-1:0]   s_data,
  input  logic [DATA_W/8-1:0] s_keep,
  input  logic                s_valid,
  input  logic                s_last,
  output logic                s_ready,
  input  logic [15:0]         seed,
  input  logic                mode,
  input  logic                flush,
  output logic [15:0]         m_chksum,
  output logic                m_ok,
  output logic [LEN_W-1:0]    m_len,
  output logic                m_valid,
  input  logic                m_ready
);

  localparam int NB    = DATA_W / 8;
  localparam int NW    = DATA_W / 16;
  // Headroom for the carried-over high part plus NW words per beat.
  localparam int ACC_W = 16 + $clog2(NW + 2);
  localparam int HI_W  = ACC_W - 16;
  localparam int PC_W  = $clog2(NB + 1);
  localparam int SAT_W = ((LEN_W > PC_W) ? LEN_W : PC_W) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------
  function automatic logic [PC_W-1:0] popcount(input logic [NB-1:0] k);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < NB; i++) begin
      c = c + PC_W'(k[i]);
    end
    return c;
  endfunction

  function automatic logic [LEN_W-1:0] len_sat_add(input logic [LEN_W-1:0] a,
                                                   input logic [PC_W-1:0]  b);
    logic [SAT_W-1:0] s;
    logic [LEN_W-1:0] r;
    s = SAT_W'(a) + SAT_W'(b);
    if (s > SAT_W'({LEN_W{1'b1}})) begin
      r = {LEN_W{1'b1}};
    end else begin
      r = s[LEN_W-1:0];
    end
    return r;
  endfunction

  // Two-step fold: the second add cannot carry out because a carry in the
  // first step leaves the low half small.
  function automatic logic [15:0] fold16(input logic [ACC_W-1:0] a);
    logic [16:0] s1;
    s1 = {1'b0, a[15:0]} + 17'(a[ACC_W-1:16]);
    return s1[15:0] + {15'd0, s1[16]};
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [15:0]        chk_q, chk_d;
  logic               ok_q, ok_d;
  logic               mode_q, mode_d;

  logic [DATA_W-1:0]  masked;
  logic [ACC_W-1:0]   beat_sum;
  logic [ACC_W-1:0]   acc_nxt;
  logic [15:0]        base_lo;
  logic [HI_W-1:0]    base_hi;
  logic [15:0]        fold_s;
  logic               first_beat;
  logic               beat_fire;
  logic               mode_eff;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. Flush overrides any beat or result handshake.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (beat_fire) state_d = s_last ? DONE : ACCUM;
        end
        ACCUM: begin
          if (beat_fire && s_last) state_d = DONE;
        end
        DONE: begin
          if (m_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    s_ready = 1'b0;
    m_valid = 1'b0;
    unique case (state_q)
      IDLE:    s_ready = 1'b1;
      ACCUM:   s_ready = 1'b1;
      DONE:    m_valid = 1'b1;
      default: s_ready = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Beat datapath
  // ---------------------------------------------------------------------------
  assign first_beat = (state_q == IDLE);
  assign beat_fire  = s_valid && s_ready && !flush;

  // Keep bit j qualifies byte lane s_data[8j+:8]; with keep MSB = byte 0 the
  // lane order lines up directly.
  always_comb begin
    masked = '0;
    for (int j = 0; j < NB; j++) begin
      masked[8*j +: 8] = s_keep[j] ? s_data[8*j +: 8] : 8'h00;
    end
  end

  always_comb begin
    beat_sum = '0;
    for (int k = 0; k < NW; k++) begin
      beat_sum = beat_sum + ACC_W'(masked[16*k +: 16]);
    end
  end

  // The first beat starts from the seed instead of the previous accumulator.
  assign base_lo  = first_beat ? seed : acc_q[15:0];
  assign base_hi  = first_beat ? '0 : acc_q[ACC_W-1:16];
  assign acc_nxt  = ACC_W'(base_lo) + ACC_W'(base_hi) + beat_sum;
  assign fold_s   = fold16(acc_nxt);
  assign mode_eff = first_beat ? mode : mode_q;

  always_comb begin
    acc_d  = acc_q;
    len_d  = len_q;
    chk_d  = chk_q;
    ok_d   = ok_q;
    mode_d = mode_q;
    if (flush) begin
      acc_d = '0;
      len_d = '0;
    end else if (beat_fire) begin
      acc_d = acc_nxt;
      len_d = len_sat_add(first_beat ? '0 : len_q, popcount(s_keep));
      if (first_beat) mode_d = mode;
      if (s_last) begin
        // Result captured on the last beat so it is ready the next cycle.
        ok_d  = (fold_s == 16'hFFFF);
        chk_d = (mode_eff && (fold_s == 16'hFFFF)) ? 16'h0000 : ~fold_s;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q  <= '0;
      len_q  <= '0;
      chk_q  <= 16'h0000;
      ok_q   <= 1'b0;
      mode_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      len_q  <= len_d;
      chk_q  <= chk_d;
      ok_q   <= ok_d;
      mode_q <= mode_d;
    end
  end

  assign m_chksum = chk_q;
  assign m_ok     = ok_q;
  assign m_len    = len_q;

endmodule

// File: tb/tb_chksum_inet_acc.sv
module tb_chksum_inet_acc;

  localparam int DATA_W = 32;
  localparam int LEN_W  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] s_data;
  logic [3:0]        s_keep;
  logic              s_valid;
  logic              s_last;
  logic              s_ready;
  logic [15:0]       seed;
  logic              mode;
  logic              flush;
  logic [15:0]       m_chksum;
  logic              m_ok;
  logic [LEN_W-1:0]  m_len;
  logic              m_valid;
  logic              m_ready;

  always #5 clk = ~clk;

  chksum_inet_acc #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .s_data   (s_data),
    .s_keep   (s_keep),
    .s_valid  (s_valid),
    .s_last   (s_last),
    .s_ready  (s_ready),
    .seed     (seed),
    .mode     (mode),
    .flush    (flush),
    .m_chksum (m_chksum),
    .m_ok     (m_ok),
    .m_len    (m_len),
    .m_valid  (m_valid),
    .m_ready  (m_ready)
  );

  typedef struct packed {
    logic [15:0]      chk;
    logic             ok;
    logic [LEN_W-1:0] len;
  } res_t;

  res_t        exp_q[$];
  res_t        mon_e;
  logic [31:0] fd[$];
  logic [3:0]  fk[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic        bp_en   = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic res_t mk(input logic [15:0] c, input logic o, input logic [LEN_W-1:0] l);
    res_t r;
    r.chk = c;
    r.ok  = o;
    r.len = l;
    return r;
  endfunction

  // Reference: byte-wise ones-complement sum with end-around carry.
  function automatic res_t model(input logic [15:0] sd, input logic md);
    int unsigned sum;
    int unsigned len;
    logic [7:0]  b;
    res_t        r;
    sum = 32'(sd);
    len = 0;
    foreach (fd[i]) begin
      for (int j = 0; j < 4; j++) begin
        if (fk[i][3-j]) begin
          b = fd[i][31-8*j -: 8];
          len++;
          sum += (j % 2 == 0) ? (32'(b) << 8) : 32'(b);
        end
      end
    end
    while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
    r.ok  = (sum == 32'hFFFF);
    r.chk = (md && r.ok) ? 16'h0000 : ~sum[15:0];
    r.len = LEN_W'(len);
    return r;
  endfunction

  // Result monitor / scoreboard pop
  always @(negedge clk) begin
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_result", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("chksum", 32'(m_chksum), 32'(mon_e.chk));
        check_eq("ok",     32'(m_ok),     32'(mon_e.ok));
        check_eq("len",    32'(m_len),    32'(mon_e.len));
      end
    end
  end

  // Random result backpressure, changed just after the rising edge
  always @(posedge clk) begin
    if (bp_en) begin
      #1;
      m_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int cnt;
    @(negedge clk);
    s_data  = d;
    s_keep  = k;
    s_last  = l;
    s_valid = 1'b1;
    cnt     = 0;
    while (!s_ready && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    if (!s_ready) check_eq("s_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
  endtask

  task automatic send_frame(input logic [15:0] sd, input logic md,
                            input logic push_exp, input res_t e);
    seed = sd;
    mode = md;
    if (push_exp) exp_q.push_back(e);
    foreach (fd[i]) send_beat(fd[i], fk[i], (i == fd.size() - 1));
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    check_eq("m_valid_latency", 32'(m_valid), 32'd1);
  endtask

  task automatic load_ip(input logic [31:0] b3);
    fd = {32'h45000073, 32'h00004000, b3, 32'hc0a80001, 32'hc0a800c7};
    fk = {4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
  endtask

  initial begin
    int n;
    logic mk_ok;
    res_t part;
    reset   = 1'b0;
    s_data  = '0;
    s_keep  = '0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    seed    = '0;
    mode    = 1'b0;
    flush   = 1'b0;
    m_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_m_valid",  32'(m_valid),  32'd0);
    check_eq("rst_m_chksum", 32'(m_chksum), 32'd0);
    check_eq("rst_m_ok",     32'(m_ok),     32'd0);
    check_eq("rst_m_len",    32'(m_len),    32'd0);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rst_s_ready",  32'(s_ready),  32'd1);

    // IP header, generate
    load_ip(32'h40110000);
    send_frame(16'h0000, 1'b0, 1'b1, mk(16'hB861, 1'b0, 16'd20));
    // Verify with the checksum inserted
    load_ip(32'h4011B861);
    send_frame(16'h0000, 1'b1, 1'b1, mk(16'h0000, 1'b1, 16'd20));
    // Verify mode on a frame that does not check
    load_ip(32'h40110000);
    send_frame(16'h0000, 1'b1, 1'b1, mk(16'hB861, 1'b0, 16'd20));
    // Odd length
    fd = {32'h12345678}; fk = {4'hE};
    send_frame(16'h0000, 1'b0, 1'b1, mk(16'h97CB, 1'b0, 16'd3));
    // Carry wrap
    fd = {32'hFFFFFFFF, 32'hFFFFFFFF}; fk = {4'hF, 4'hF};
    send_frame(16'h0001, 1'b0, 1'b1, mk(16'hFFFE, 1'b0, 16'd8));
    // All-zero data: never -0
    fd = {32'h00000000}; fk = {4'hF};
    send_frame(16'h0000, 1'b0, 1'b1, mk(16'hFFFF, 1'b0, 16'd4));
    send_frame(16'h0000, 1'b1, 1'b1, mk(16'hFFFF, 1'b0, 16'd4));
    // Empty-keep beat is legal and contributes nothing
    fd = {32'hAAAAAAAA, 32'h00010002}; fk = {4'h0, 4'hF};
    send_frame(16'h0000, 1'b0, 1'b1, mk(16'hFFFC, 1'b0, 16'd4));

    // Backpressure in DONE, then flush the pending result
    @(negedge clk);
    m_ready = 1'b0;
    load_ip(32'h40110000);
    send_frame(16'h0000, 1'b0, 1'b0, mk(16'h0, 1'b0, 16'd0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("bp_s_ready", 32'(s_ready),  32'd0);
      check_eq("bp_m_valid", 32'(m_valid),  32'd1);
      check_eq("bp_chksum",  32'(m_chksum), 32'hB861);
      check_eq("bp_len",     32'(m_len),    32'd20);
      check_eq("bp_ok",      32'(m_ok),     32'd0);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_eq("flush_m_valid", 32'(m_valid), 32'd0);
    check_eq("flush_s_ready", 32'(s_ready), 32'd1);
    check_eq("flush_len",     32'(m_len),   32'd0);
    m_ready = 1'b1;

    // Flush beats a simultaneous last beat mid-frame
    seed = 16'h0000; mode = 1'b0;
    send_beat(32'h45000073, 4'hF, 1'b0);
    @(negedge clk);
    s_data = 32'hFFFFFFFF; s_keep = 4'hF; s_valid = 1'b1; s_last = 1'b1;
    flush  = 1'b1;
    @(negedge clk);
    flush = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    check_eq("flush_beat_m_valid", 32'(m_valid), 32'd0);
    check_eq("flush_beat_len",     32'(m_len),   32'd0);
    load_ip(32'h40110000);
    send_frame(16'h0000, 1'b0, 1'b1, mk(16'hB861, 1'b0, 16'd20));

    // Reset mid-frame
    load_ip(32'h40110000);
    seed = 16'h0000; mode = 1'b0;
    send_beat(fd[0], fk[0], 1'b0);
    send_beat(fd[1], fk[1], 1'b0);
    @(negedge clk);
    s_valid = 1'b0;
    check_eq("mid_len", 32'(m_len), 32'd8);
    reset = 1'b0;
    #1;
    check_eq("async_rst_len",     32'(m_len),   32'd0);
    check_eq("async_rst_s_ready", 32'(s_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    send_frame(16'h0000, 1'b0, 1'b1, mk(16'hB861, 1'b0, 16'd20));

    // Random frames with random result backpressure
    bp_en = 1'b1;
    for (int f = 0; f < 24; f++) begin
      n     = $urandom_range(1, 6);
      mk_ok = ($urandom_range(0, 2) == 0);
      seed  = 16'($urandom);
      fd.delete(); fk.delete();
      for (int b = 0; b < (mk_ok ? n - 1 : n); b++) begin
        fd.push_back($urandom);
        fk.push_back(4'($urandom_range(0, 15)));
      end
      if (mk_ok) begin
        part = model(seed, 1'b0);
        fd.push_back({part.chk, 16'h0000});
        fk.push_back(4'hF);
      end
      send_frame(seed, 1'($urandom_range(0, 1)), 1'b1, model(seed, mode));
    end
    bp_en = 1'b0;
    @(negedge clk);
    m_ready = 1'b1;
    for (int w = 0; w < 50 && exp_q.size() != 0; w++) @(negedge clk);
    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
